mul_para_a_arb: RTL and testbench

MUL_PARA_A_ARB -- requirements
Module: mul_para_a_arb

---
 rtl/mul_para_a_arb_pkg.sv | 21 ++
 rtl/mul_arb_tag_pipe.sv | 52 +++++
 rtl/mul_para_a_arb.sv | 124 ++++++++++++
 tb/tb_mul_para_a_arb.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_para_a_arb_pkg.sv
// Shared definitions for the two-requester multiplier front end.
//   DEF_DW_IN / DEF_DW_OUT : default operand / product widths
//   ID_W                   : width of the requester id carried with each operand
//   pri_t                  : round-robin pointer (which requester wins a tie)
package mul_para_a_arb_pkg;

    localparam int DEF_DW_IN  = 16;
    localparam int DEF_DW_OUT = 23;
    localparam int ID_W       = 1;

    typedef logic [ID_W-1:0] req_id_t;

    localparam req_id_t REQ0_ID = req_id_t'(0);
    localparam req_id_t REQ1_ID = req_id_t'(1);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

endpackage : mul_para_a_arb_pkg

// File: rtl/mul_arb_tag_pipe.sv
// Valid + requester-id delay line that travels alongside each operand through
// the external multiplier, so the product can be steered back to its owner.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : an operand is issued this cycle
//   in_id       : requester that owns the issued operand
//   out_valid   : tag leaving the last stage (aligned with the product)
//   out_id      : owner of that product
//   any_valid   : OR of every stage valid bit
module mul_arb_tag_pipe
    import mul_para_a_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id,
    output logic    any_valid
);

    logic [DEPTH-1:0] valid_q;
    req_id_t          id_q [DEPTH];

    // NOTE: sequential state always uses non-blocking assignments so every
    // stage samples the previous stage's old value on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // NOTE: only the valid bits need reset; the id payload is never looked
    // at while its valid is low, so it is left as plain unreset storage.
    always_ff @(posedge clk) begin
        id_q[0] <= in_id;
        for (int i = 1; i < DEPTH; i++) begin
            id_q[i] <= id_q[i-1];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];
    assign any_valid = |valid_q;

endmodule : mul_arb_tag_pipe

// File: rtl/mul_para_a_arb.sv
// Round-robin arbiter sharing one external pipelined constant multiplier
// between two requesters. The granted operand is registered onto mul_a, its
// owner id rides a tag pipeline, and the product is registered back to the
// owner as a single-cycle response pulse MUL_LAT+2 cycles after acceptance.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqN_valid/data/ready       : operand handshake for requester N (0/1)
//   mul_a                       : registered operand to the multiplier
//   mul_p                       : product, valid MUL_LAT cycles after mul_a
//   rspN_valid/data             : response pulse and held product for N
//   busy                        : any operand still awaiting its response
module mul_para_a_arb
    import mul_para_a_arb_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DW_IN   = DEF_DW_IN,
    parameter int DW_OUT  = DEF_DW_OUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DW_IN-1:0]  req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DW_IN-1:0]  req1_data,
    output logic              req1_ready,
    output logic [DW_IN-1:0]  mul_a,
    input  logic [DW_OUT-1:0] mul_p,
    output logic              rsp0_valid,
    output logic [DW_OUT-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DW_OUT-1:0] rsp1_data,
    output logic              busy
);

    pri_t    pri_q;
    pri_t    pri_d;
    logic    gnt0;
    logic    gnt1;
    logic    issue;
    req_id_t issue_id;
    logic    tag_valid;
    req_id_t tag_id;
    logic    tag_any;

    // Grant logic. Ready is gated by rst_n so nothing is accepted while the
    // block is held in reset. A lone requester always wins; on a tie the
    // pointer decides.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        pri_d = pri_q;
        if (rst_n) begin
            if (req0_valid && (!req1_valid || pri_q == PRI0)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            pri_d = PRI1;
        end else if (gnt1) begin
            pri_d = PRI0;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign issue      = gnt0 | gnt1;
    assign issue_id   = gnt1 ? REQ1_ID : REQ0_ID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= PRI0;
            mul_a <= '0;
        end else begin
            pri_q <= pri_d;
            if (gnt0) begin
                mul_a <= req0_data;
            end else if (gnt1) begin
                mul_a <= req1_data;
            end
        end
    end

    // Depth MUL_LAT+1: one stage for the mul_a register plus MUL_LAT for the
    // multiplier, so out_valid lines up with the product on mul_p.
    mul_arb_tag_pipe #(
        .DEPTH (MUL_LAT + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .in_id     (issue_id),
        .out_valid (tag_valid),
        .out_id    (tag_id),
        .any_valid (tag_any)
    );

    // Response register: steer the product to its owner; data holds between
    // pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= tag_valid && (tag_id == REQ0_ID);
            rsp1_valid <= tag_valid && (tag_id == REQ1_ID);
            if (tag_valid && (tag_id == REQ0_ID)) begin
                rsp0_data <= mul_p;
            end
            if (tag_valid && (tag_id == REQ1_ID)) begin
                rsp1_data <= mul_p;
            end
        end
    end

    // The response register acts as the final tag stage.
    assign busy = tag_any | rsp0_valid | rsp1_valid;

endmodule : mul_para_a_arb

// File: tb/tb_mul_para_a_arb.sv
// Self-checking bench for mul_para_a_arb with a K=7, 3-cycle model multiplier.
// A scoreboard queue receives the expected product, owner and arrival cycle
// for every accepted operand; response pulses pop and compare against it.
module tb_mul_para_a_arb;

    localparam int MUL_LAT = 3;
    localparam int DW_IN   = 16;
    localparam int DW_OUT  = 23;
    localparam int K       = 7;
    localparam int RSP_LAT = MUL_LAT + 2;

    typedef struct {
        logic              id;
        logic [DW_OUT-1:0] data;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0_valid = 1'b0;
    logic [DW_IN-1:0]  req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [DW_IN-1:0]  req1_data = '0;
    logic              req1_ready;
    logic [DW_IN-1:0]  mul_a;
    logic [DW_OUT-1:0] mul_p;
    logic              rsp0_valid;
    logic [DW_OUT-1:0] rsp0_data;
    logic              rsp1_valid;
    logic [DW_OUT-1:0] rsp1_data;
    logic              busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t e;

    mul_para_a_arb #(
        .MUL_LAT (MUL_LAT),
        .DW_IN   (DW_IN),
        .DW_OUT  (DW_OUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .mul_a      (mul_a),
        .mul_p      (mul_p),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model multiplier: never reset, keeps shifting through reset.
    logic [DW_OUT-1:0] p_pipe [MUL_LAT];
    initial for (int i = 0; i < MUL_LAT; i++) p_pipe[i] = '0;
    always @(posedge clk) begin
        p_pipe[0] <= DW_OUT'(mul_a) * DW_OUT'(K);
        for (int i = 1; i < MUL_LAT; i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign mul_p = p_pipe[MUL_LAT-1];

    // Protocol checks, scoreboard pop on responses, scoreboard push on accepts.
    always @(negedge clk) begin
        checks++;
        if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid) ||
            (req0_ready && req1_ready)) begin
            failures++;
            $display("FAIL grant_protocol cyc=%0d ready=%b%b valid=%b%b",
                     cyc, req1_ready, req0_ready, req1_valid, req0_valid);
        end
        if (rsp0_valid || rsp1_valid) begin
            checks++;
            if (rsp0_valid && rsp1_valid) begin
                failures++;
                $display("FAIL rsp_both cyc=%0d got both pulses, want at most one", cyc);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected cyc=%0d rsp0=%b rsp1=%b with nothing outstanding",
                         cyc, rsp0_valid, rsp1_valid);
            end else begin
                e = sb.pop_front();
                if (rsp1_valid !== e.id ||
                    (rsp1_valid ? rsp1_data : rsp0_data) !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL rsp_sb got id=%0d data=0x%0h cyc=%0d want id=%0d data=0x%0h cyc=%0d",
                             rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data, cyc,
                             e.id, e.data, e.cyc);
                end
            end
        end
        if (req0_valid && req0_ready)
            sb.push_back('{1'b0, DW_OUT'(req0_data) * DW_OUT'(K), cyc + RSP_LAT});
        if (req1_valid && req1_ready)
            sb.push_back('{1'b1, DW_OUT'(req1_data) * DW_OUT'(K), cyc + RSP_LAT});
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL drain busy=%b outstanding=%0d want busy=0 outstanding=0", busy, sb.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 16'h1234;
        req1_data  = 16'h4321;
        repeat (2) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
        end
        checks++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_valids busy/rsp0/rsp1 got %b%b%b want 000", busy, rsp0_valid, rsp1_valid);
        end
        checks++;
        if (mul_a !== '0 || rsp0_data !== '0 || rsp1_data !== '0) begin
            failures++;
            $display("FAIL reset_data mul_a=0x%0h rsp0=0x%0h rsp1=0x%0h want all 0", mul_a, rsp0_data, rsp1_data);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int c0, n0, n1, lat;
        n0 = 0; n1 = 0; lat = -1;
        req0_valid = 1'b1;
        req0_data  = 16'h0100;
        @(negedge clk);
        c0 = cyc;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_accept req0_ready=%b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin n0++; lat = cyc - c0; end
            if (rsp1_valid) n1++;
        end
        checks++;
        if (n0 != 1 || lat != RSP_LAT || n1 != 0) begin
            failures++;
            $display("FAIL single_rsp pulses0=%0d latency=%0d pulses1=%0d want 1/%0d/0", n0, lat, n1, RSP_LAT);
        end
        checks++;
        if (rsp0_data !== 23'h00700) begin
            failures++;
            $display("FAIL single_hold rsp0_data=0x%0h want 0x700", rsp0_data);
        end
        wait_idle();
    endtask

    task automatic test_contention();
        int nrsp, first_c, last_c;
        nrsp = 0; first_c = -1; last_c = -1;
        apply_reset();
        req0_valid = 1'b1; req0_data = 16'h0001;
        req1_valid = 1'b1; req1_data = 16'h0002;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                    failures++;
                    $display("FAIL contention_grant step=%0d ready0=%b ready1=%b want %0d/%0d",
                             i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
                end
            end
            if (rsp0_valid || rsp1_valid) begin
                checks++;
                if (rsp1_valid !== nrsp[0] ||
                    (rsp1_valid ? rsp1_data : rsp0_data) !== (nrsp[0] ? 23'd14 : 23'd7)) begin
                    failures++;
                    $display("FAIL contention_rsp n=%0d rsp1=%b data=0x%0h want rsp1=%0d data=%0d",
                             nrsp, rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data,
                             nrsp % 2, nrsp[0] ? 14 : 7);
                end
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                nrsp++;
            end
            tick();
            if (i == 7) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        checks++;
        if (nrsp != 8 || last_c - first_c != 7) begin
            failures++;
            $display("FAIL contention_count pulses=%0d span=%0d want 8/7", nrsp, last_c - first_c);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [DW_OUT-1:0] want;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                req1_valid = 1'b1;
                req1_data  = DW_IN'(16'h0010 + i);
            end else begin
                req1_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (req1_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_accept step=%0d req1_ready=%b want 1", i, req1_ready);
                end
            end
            if (i >= 1 && i <= 13) begin
                checks++;
                if (busy !== (i <= 12)) begin
                    failures++;
                    $display("FAIL b2b_busy step=%0d busy=%b want %0d", i, busy, i <= 12);
                end
            end
            want = DW_OUT'(16'h0070 + 7 * (i - 5));
            checks++;
            if (rsp1_valid !== (i >= 5 && i <= 12) ||
                (rsp1_valid && rsp1_data !== want)) begin
                failures++;
                $display("FAIL b2b_rsp step=%0d rsp1_valid=%b data=0x%0h want valid=%0d data=0x%0h",
                         i, rsp1_valid, rsp1_data, i >= 5 && i <= 12, want);
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_pointer_hold();
        apply_reset();
        req0_valid = 1'b1; req0_data = 16'h0005;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL ptr_lone req0_ready=%b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        req0_valid = 1'b1; req0_data = 16'h0009;
        req1_valid = 1'b1; req1_data = 16'h000A;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL ptr_hold ready0/1 got %b%b want 01", req0_ready, req1_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL ptr_next ready0/1 got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_midflight();
        int npulse;
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1;
            req0_data  = DW_IN'(16'h0021 + i);
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b1) begin
                failures++;
                $display("FAIL mid_accept step=%0d req0_ready=%b want 1", i, req0_ready);
            end
            tick();
        end
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mul_a !== '0 || rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset busy=%b mul_a=0x%0h rsp0_valid=%b want 0/0/0", busy, mul_a, rsp0_valid);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) npulse++;
        end
        checks++;
        if (npulse != 0) begin
            failures++;
            $display("FAIL mid_discard active_cycles=%0d want 0", npulse);
        end
        tick();
        req0_valid = 1'b1; req0_data = 16'h0003;
        req1_valid = 1'b1; req1_data = 16'h0004;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL mid_ptr ready0/1 got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_pointer_hold();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mul_para_a_arb
